tl_traffic_model: RTL and testbench
===================================

# tl_traffic_model

Synthesizable intersection model at the far end of the traffic-light controller interface: it consumes the light codes La/Lb and produces the vehicle sensor signals Ta/Tal/Tb/Tbl. It keeps four vehicle queues: A through, A left, B through and B left. Arrival pulses fill the queues, and departures drain them only when the matching light permits. It also flags queue overflow and conflicting green indications. Used in closed-loop simulation and on-board demo against the controller.

## Interface
Parameters:
- QMAX, 7: maximum vehicles per queue; count width CW = $clog2(QMAX+1).
- GAP, 2: cycles a lane must wait after a departure before its next departure (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- La  in  2  light code for road A (package encoding).
- Lb  in  2  light code for road B.
- arr_a, arr_al, arr_b, arr_bl  in  1 each  one-cycle vehicle arrival pulse per lane.
- Ta, Tal, Tb, Tbl  out  1 each  lane queue non-empty.
- cnt_a, cnt_al, cnt_b, cnt_bl  out  CW each  current queue occupancy.
- dep_a, dep_al, dep_b, dep_bl  out  1 each  one-cycle pulse, vehicle left lane.
- overflow  out  1  sticky: an arrival was dropped at QMAX.
- conflict  out  1  sticky: A and B both non-RED in the same cycle.

## Operation
- Light codes: GREEN=2'b00, YELLOW=2'b01, RED=2'b10, LEFT=2'b11.
- Permission per lane:
  - A through departs only while La==GREEN; A left only while La==LEFT.
  - B lanes use Lb the same way.
  - YELLOW and RED permit no departures.
- Lane registers: count[CW-1:0] and gap[$clog2(GAP+1)-1:0].
- Each cycle, per lane:
  - dep_ok = permit && count!=0 && gap==0.
  - If dep_ok: load gap with GAP and assert dep_x next cycle. Otherwise, if gap!=0, decrement gap; gap counts down regardless of light.
  - Count update:
    - arrival and no dep_ok: increment, saturating at QMAX.
    - dep_ok and no arrival: decrement.
    - both: unchanged.
    - neither: unchanged.
  - An arrival with count==QMAX and no same-cycle dep_ok is dropped and sets overflow.
- T outputs are combinational: Tx = (count_x != 0).
- conflict sets when La!=RED && Lb!=RED in a sampled cycle. overflow and conflict stay set until reset.
- Light changes mid-gap do not clear gap; the lane resumes after the gap expires once permitted again.
- Lanes are fully independent, so A-left and B-through may depart in the same cycle.

## Timing
- Reset values: all counts 0, all gaps 0, all dep_x 0, overflow 0, conflict 0. Hence T outputs are 0.
- Reset mid-operation discards all queued vehicles on the next edge. Arrivals sampled while reset is high are ignored.
- Arrival sampled at edge k: count+1 visible after edge k, Tx rises in the same cycle.
- Departure decided at edge k: count−1 and dep_x=1 after edge k, dep_x low after edge k+1.
- Back-to-back departures on one permitted lane are spaced GAP+1 cycles.
- A permission edge has zero latency: the first edge sampled with La==GREEN can depart a vehicle.
- overflow and conflict assert after the offending edge.

## Structure
- Package tl_pkg: light-code localparams (GREEN, YELLOW, RED, LEFT) and the typedef light_t (2-bit). The controller side shares this package.
- Sub-module tl_lane_queue (params QMAX, GAP; ports clk, reset, permit, arr, count, t, dep, drop), instantiated four times.
- Top level contains the permit decode from La/Lb, overflow = sticky OR of the four drop signals, and the conflict register.

## Test plan
- Reset, then 3 arr_a pulses with La=RED: cnt_a=3, Ta=1, no dep_a. With La=GREEN, GAP=2: dep_a pulses every 3 cycles, cnt_a 3→2→1→0, Ta falls with the last departure.
- La=LEFT with cnt_a=2 and cnt_al=2: only the A-left queue drains; cnt_a stays 2. La=YELLOW: nothing drains.
- QMAX=7: 9 arrivals on arr_bl with Lb=RED → cnt_bl=7, overflow=1 after the 8th arrival and stays 1.
- Simultaneous arr_b and a permitted departure at cnt_b=7 → cnt_b stays 7, dep_b=1, overflow unchanged.
- La=GREEN with Lb=LEFT for one cycle → conflict=1, held through later legal lights, cleared only by reset.
- Reset asserted with cnt_a=5 and gap running → next cycle cnt_a=0, Ta=0, dep_a=0; an arrival in the reset cycle is not counted.

Source files
------------

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - light codes shared by the traffic-light controller and the intersection model
package tl_pkg;

  typedef logic [1:0] light_t;

  localparam light_t GREEN  = 2'b00;
  localparam light_t YELLOW = 2'b01;
  localparam light_t RED    = 2'b10;
  localparam light_t LEFT   = 2'b11;

endpackage

// File: rtl/tl_traffic_model_if.sv
// rtl/tl_traffic_model_if.sv - light/arrival inputs and sensor/queue outputs of the intersection model
interface tl_traffic_model_if #(parameter int QMAX = 7);
  import tl_pkg::*;
  localparam int CW = $clog2(QMAX + 1);

  light_t          La;
  light_t          Lb;
  logic            arr_a, arr_al, arr_b, arr_bl;
  logic            Ta, Tal, Tb, Tbl;
  logic [CW-1:0]   cnt_a, cnt_al, cnt_b, cnt_bl;
  logic            dep_a, dep_al, dep_b, dep_bl;
  logic            overflow;
  logic            conflict;

  // master is the controller/stimulus side, slave is the intersection model
  modport master (
    output La, Lb, arr_a, arr_al, arr_b, arr_bl,
    input  Ta, Tal, Tb, Tbl, cnt_a, cnt_al, cnt_b, cnt_bl,
    input  dep_a, dep_al, dep_b, dep_bl, overflow, conflict
  );

  modport slave (
    input  La, Lb, arr_a, arr_al, arr_b, arr_bl,
    output Ta, Tal, Tb, Tbl, cnt_a, cnt_al, cnt_b, cnt_bl,
    output dep_a, dep_al, dep_b, dep_bl, overflow, conflict
  );

endinterface

// File: rtl/tl_lane_queue.sv
// rtl/tl_lane_queue.sv - one vehicle queue: saturating occupancy plus a post-departure gap timer
module tl_lane_queue #(
  parameter int  QMAX = 7,
  parameter int  GAP  = 2,
  localparam int CW   = $clog2(QMAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          permit,
  input  logic          arr,
  output logic [CW-1:0] count,
  output logic          t,
  output logic          dep,
  output logic          drop
);

  localparam int GW = $clog2(GAP + 1);

  logic [CW-1:0] r_count;
  logic [GW-1:0] r_gap;
  logic          r_dep;
  logic          w_dep_ok;
  logic          w_full;

  assign w_full   = (r_count == CW'(QMAX));
  assign w_dep_ok = permit && (r_count != '0) && (r_gap == '0);
  // a departing vehicle frees its slot in the same cycle, so a full queue can still accept
  assign drop     = arr && !w_dep_ok && w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_gap   <= '0;
      r_dep   <= 1'b0;
    end else begin
      r_dep <= w_dep_ok;
      if (w_dep_ok) begin
        r_gap <= GW'(GAP);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
      if (arr && !w_dep_ok && !w_full) begin
        r_count <= r_count + CW'(1);
      end else if (w_dep_ok && !arr) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign count = r_count;
  assign t     = (r_count != '0);
  assign dep   = r_dep;

endmodule

// File: rtl/tl_traffic_model.sv
// rtl/tl_traffic_model.sv - four-lane intersection model driven by light codes La/Lb
module tl_traffic_model import tl_pkg::*; #(
  parameter int QMAX = 7,
  parameter int GAP  = 2
) (
  input logic              clk,
  input logic              reset,
  tl_traffic_model_if.slave bus
);

  localparam int CW = $clog2(QMAX + 1);

  logic [3:0]    w_permit;
  logic [3:0]    w_arr;
  logic [3:0]    w_t;
  logic [3:0]    w_dep;
  logic [3:0]    w_drop;
  logic [CW-1:0] w_cnt [4];
  logic          r_overflow;
  logic          r_conflict;

  // lane order: A through, A left, B through, B left
  assign w_permit[0] = (bus.La == GREEN);
  assign w_permit[1] = (bus.La == LEFT);
  assign w_permit[2] = (bus.Lb == GREEN);
  assign w_permit[3] = (bus.Lb == LEFT);
  assign w_arr       = {bus.arr_bl, bus.arr_b, bus.arr_al, bus.arr_a};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    tl_lane_queue #(.QMAX(QMAX), .GAP(GAP)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .permit (w_permit[i]),
      .arr    (w_arr[i]),
      .count  (w_cnt[i]),
      .t      (w_t[i]),
      .dep    (w_dep[i]),
      .drop   (w_drop[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (|w_drop);
      r_conflict <= r_conflict | ((bus.La != RED) && (bus.Lb != RED));
    end
  end

  assign bus.cnt_a    = w_cnt[0];
  assign bus.cnt_al   = w_cnt[1];
  assign bus.cnt_b    = w_cnt[2];
  assign bus.cnt_bl   = w_cnt[3];
  assign bus.Ta       = w_t[0];
  assign bus.Tal      = w_t[1];
  assign bus.Tb       = w_t[2];
  assign bus.Tbl      = w_t[3];
  assign bus.dep_a    = w_dep[0];
  assign bus.dep_al   = w_dep[1];
  assign bus.dep_b    = w_dep[2];
  assign bus.dep_bl   = w_dep[3];
  assign bus.overflow = r_overflow;
  assign bus.conflict = r_conflict;

endmodule

// File: tb/tb_tl_traffic_model.sv
// tb/tb_tl_traffic_model.sv - directed and random stimulus against a cycle-stamped queue model
module tb_tl_traffic_model;
  import tl_pkg::*;

  localparam int QMAX = 7;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic reset;

  tl_traffic_model_if #(.QMAX(QMAX)) bus ();

  tl_traffic_model #(.QMAX(QMAX), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model: lane occupancy and the cycle of the lane's most recent departure
  int m_cnt [4];
  int m_last [4];
  bit m_dep [4];
  bit m_ovf;
  bit m_cfl;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input light_t la, input light_t lb, input logic [3:0] arr, input bit rst);
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_last[i] = -1000; m_dep[i] = 0;
      end
      m_ovf = 0; m_cfl = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        light_t lt = (i < 2) ? la : lb;
        bit permit = (i % 2 == 0) ? (lt == GREEN) : (lt == LEFT);
        bit ok = permit && m_cnt[i] > 0 && (cyc - m_last[i] > GAP);
        m_dep[i] = ok;
        if (ok) m_last[i] = cyc;
        if (arr[i] && !ok) begin
          if (m_cnt[i] == QMAX) m_ovf = 1;
          else m_cnt[i]++;
        end else if (ok && !arr[i]) begin
          m_cnt[i]--;
        end
      end
      if (la != RED && lb != RED) m_cfl = 1;
    end
  endtask

  task automatic step(input light_t la, input light_t lb, input logic [3:0] arr, input bit rst);
    @(negedge clk);
    reset  = rst;
    bus.La = la;
    bus.Lb = lb;
    {bus.arr_bl, bus.arr_b, bus.arr_al, bus.arr_a} = arr;
    model_edge(la, lb, arr, rst);
    @(posedge clk);
    #1;
    check_eq("cnt_a",  bus.cnt_a,  m_cnt[0]);
    check_eq("cnt_al", bus.cnt_al, m_cnt[1]);
    check_eq("cnt_b",  bus.cnt_b,  m_cnt[2]);
    check_eq("cnt_bl", bus.cnt_bl, m_cnt[3]);
    check_eq("Ta",  bus.Ta,  m_cnt[0] != 0);
    check_eq("Tal", bus.Tal, m_cnt[1] != 0);
    check_eq("Tb",  bus.Tb,  m_cnt[2] != 0);
    check_eq("Tbl", bus.Tbl, m_cnt[3] != 0);
    check_eq("dep_a",  bus.dep_a,  m_dep[0]);
    check_eq("dep_al", bus.dep_al, m_dep[1]);
    check_eq("dep_b",  bus.dep_b,  m_dep[2]);
    check_eq("dep_bl", bus.dep_bl, m_dep[3]);
    check_eq("overflow", bus.overflow, m_ovf);
    check_eq("conflict", bus.conflict, m_cfl);
  endtask

  light_t la_r, lb_r;
  logic [3:0] arr_r;

  initial begin
    reset = 1'b1;
    bus.La = RED; bus.Lb = RED;
    {bus.arr_bl, bus.arr_b, bus.arr_al, bus.arr_a} = 4'b0;

    step(RED, RED, 4'b0000, 1);
    step(RED, RED, 4'b0000, 1);
    check_eq("reset_cnt_a", bus.cnt_a, 0);
    check_eq("reset_ovf", bus.overflow, 0);

    // three A-through arrivals under red, then drain on green
    repeat (3) step(RED, RED, 4'b0001, 0);
    check_eq("plan_cnt_a_3", bus.cnt_a, 3);
    check_eq("plan_Ta_1", bus.Ta, 1);
    step(GREEN, RED, 4'b0000, 0);
    check_eq("plan_first_dep", bus.dep_a, 1);
    check_eq("plan_cnt_a_2", bus.cnt_a, 2);
    repeat (9) step(GREEN, RED, 4'b0000, 0);
    check_eq("plan_drained", bus.cnt_a, 0);

    // left arrow drains only the A-left queue; yellow drains nothing
    repeat (2) step(RED, RED, 4'b0011, 0);
    repeat (8) step(LEFT, RED, 4'b0000, 0);
    check_eq("left_cnt_a", bus.cnt_a, 2);
    check_eq("left_cnt_al", bus.cnt_al, 0);
    repeat (2) step(RED, RED, 4'b0010, 0);
    repeat (6) step(YELLOW, RED, 4'b0000, 0);
    check_eq("yellow_cnt_al", bus.cnt_al, 2);

    // overflow on B-left
    step(RED, RED, 4'b0000, 1);
    repeat (7) step(RED, RED, 4'b1000, 0);
    check_eq("ovf_before_8th", bus.overflow, 0);
    step(RED, RED, 4'b1000, 0);
    check_eq("ovf_after_8th", bus.overflow, 1);
    step(RED, RED, 4'b1000, 0);
    check_eq("ovf_cnt_bl", bus.cnt_bl, 7);

    // full queue with simultaneous arrival and departure
    step(RED, RED, 4'b0000, 1);
    repeat (7) step(RED, RED, 4'b0100, 0);
    step(RED, GREEN, 4'b0100, 0);
    check_eq("full_cnt_b", bus.cnt_b, 7);
    check_eq("full_dep_b", bus.dep_b, 1);
    check_eq("full_ovf", bus.overflow, 0);

    // conflict is sticky until reset
    step(GREEN, LEFT, 4'b0000, 0);
    check_eq("cfl_set", bus.conflict, 1);
    repeat (3) step(RED, GREEN, 4'b0000, 0);
    check_eq("cfl_held", bus.conflict, 1);
    step(RED, RED, 4'b0000, 1);
    check_eq("cfl_cleared", bus.conflict, 0);

    // reset mid-operation with gap running; arrival during reset ignored
    repeat (6) step(RED, RED, 4'b0001, 0);
    step(GREEN, RED, 4'b0000, 0);
    check_eq("mid_cnt_a_5", bus.cnt_a, 5);
    step(GREEN, RED, 4'b0001, 1);
    check_eq("mid_cnt_a_0", bus.cnt_a, 0);
    check_eq("mid_Ta_0", bus.Ta, 0);
    check_eq("mid_dep_a_0", bus.dep_a, 0);

    // random phase: lights dwell for a few cycles, sparse arrivals, rare resets
    la_r = RED; lb_r = RED;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) la_r = light_t'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) lb_r = light_t'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) arr_r[i] = ($urandom_range(0, 3) == 0);
      step(la_r, lb_r, arr_r, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
